// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge detector.
package sobel_pkg;

  typedef enum logic [1:0] {
    SOB_SUM = 2'd0,
    SOB_H   = 2'd1,
    SOB_V   = 2'd2,
    SOB_THR = 2'd3
  } sob_mode_e;

  localparam int SOB_PIX_W = 8;
  localparam int GRAD_W    = SOB_PIX_W + 4;
  localparam int SOB_LAT   = 3;

  function automatic logic [31:0] saturate(input logic [31:0] v, input logic [31:0] maxv);
    return (v > maxv) ? maxv : v;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel storage: simple dual-port RAM, 1-cycle read, read-before-write.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_X = 800,
  parameter int X_W   = 10
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [X_W-1:0]   wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [X_W-1:0]   rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [MAX_X];

  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel gradient magnitude with run-time line length and output mode.
// Define SOBEL_THRESH_EN to build the threshold output mode (mode 3).
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_X = 800,
  parameter int X_W   = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [X_W-1:0]   line_len,
  input  logic [1:0]       mode,
  input  logic [PIX_W+3:0] thresh,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sof,
  output logic             out_eol,
  output logic             err
);

  localparam int GW = PIX_W + 4;
  localparam int AW = PIX_W + 3;
  localparam logic [X_W-1:0] MAX_M1 = X_W'(MAX_X - 1);
  localparam logic [31:0]    PMAX   = (32'd1 << PIX_W) - 32'd1;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  function automatic logic [AW-1:0] mag(input logic signed [GW-1:0] v);
    return AW'((v < 0) ? -v : v);
  endfunction

  // Frame control state
  logic           active;
  logic [X_W-1:0] x_q, lm1_q;
  logic [15:0]    y_q;
  sob_mode_e      mode_q;

  logic           acc, len_bad, mode_bad, x_last, win;
  logic [X_W-1:0] cur_x, cur_lm1, len_m1_eff;
  logic [15:0]    cur_y;
  sob_mode_e      mode_eff, mode_cur;

  logic beat_p0, vld_p0, sof_p0, eol_p0;
  logic vld_p1, sof_p1, eol_p1;
  logic vld_p2, sof_p2, eol_p2;

  logic [PIX_W-1:0]     pix_p0, lb0_q, lb1_q;
  logic [X_W-1:0]       wa_p0;
  sob_mode_e            mode_p0, mode_p1, mode_p2;
  logic [PIX_W-1:0]     w0 [2];
  logic [PIX_W-1:0]     w1 [2];
  logic [PIX_W-1:0]     w2 [2];
  logic signed [GW-1:0] h_p1, v_p1;
  logic [AW-1:0]        ah_p2, av_p2;
  logic [GW-1:0]        sum_p2, s_p2;
  logic [PIX_W-1:0]     pix_res;

`ifdef SOBEL_THRESH_EN
  logic [GW-1:0] thr_q, thr_cur, thr_p0, thr_p1, thr_p2;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  always_comb begin
    acc        = in_valid && (active || in_sof);
    len_bad    = (32'(line_len) < 32'd3) || (32'(line_len) > 32'(MAX_X));
    len_m1_eff = len_bad ? MAX_M1 : line_len - 1'b1;
`ifdef SOBEL_THRESH_EN
    mode_bad   = 1'b0;
    mode_eff   = sob_mode_e'(mode);
    thr_cur    = in_sof ? thresh : thr_q;
`else
    // Without the comparator, mode 3 falls back to |H|+|V| and flags err.
    mode_bad   = (mode == 2'd3);
    mode_eff   = mode_bad ? SOB_SUM : sob_mode_e'(mode);
`endif
    cur_x      = in_sof ? '0 : x_q;
    cur_y      = in_sof ? '0 : y_q;
    cur_lm1    = in_sof ? len_m1_eff : lm1_q;
    mode_cur   = in_sof ? mode_eff : mode_q;
    x_last     = (cur_x == cur_lm1);
    win        = (cur_x >= X_W'(2)) && (cur_y >= 16'd2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      lm1_q     <= '0;
      mode_q    <= SOB_SUM;
      err       <= 1'b0;
`ifdef SOBEL_THRESH_EN
      thr_q     <= '0;
`endif
      beat_p0   <= 1'b0;
      vld_p0    <= 1'b0;
      sof_p0    <= 1'b0;
      eol_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      sof_p1    <= 1'b0;
      eol_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      sof_p2    <= 1'b0;
      eol_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_pix   <= '0;
    end else begin
      beat_p0   <= acc;
      vld_p0    <= acc && win;
      sof_p0    <= acc && win && (cur_x == X_W'(2)) && (cur_y == 16'd2);
      eol_p0    <= acc && win && x_last;
      vld_p1    <= vld_p0;
      sof_p1    <= sof_p0;
      eol_p1    <= eol_p0;
      vld_p2    <= vld_p1;
      sof_p2    <= sof_p1;
      eol_p2    <= eol_p1;
      out_valid <= vld_p2;
      out_sof   <= sof_p2;
      out_eol   <= eol_p2;
      out_pix   <= vld_p2 ? pix_res : '0;
      if (acc) begin
        active <= 1'b1;
        x_q    <= x_last ? '0 : cur_x + 1'b1;
        y_q    <= (x_last && (cur_y != 16'hFFFF)) ? cur_y + 1'b1 : cur_y;
        if (in_sof) begin
          lm1_q  <= len_m1_eff;
          mode_q <= mode_eff;
          err    <= len_bad || mode_bad;
`ifdef SOBEL_THRESH_EN
          thr_q  <= thresh;
`endif
        end
      end
    end
  end

  // lb0 is written one beat late because its data is the lb1 read result.
  sobel_line_buf #(.PIX_W(PIX_W), .MAX_X(MAX_X), .X_W(X_W)) u_lb1 (
    .clock   (clock),
    .wr_en   (acc),
    .wr_addr (cur_x),
    .wr_data (in_pix),
    .rd_en   (acc),
    .rd_addr (cur_x),
    .rd_data (lb1_q)
  );

  sobel_line_buf #(.PIX_W(PIX_W), .MAX_X(MAX_X), .X_W(X_W)) u_lb0 (
    .clock   (clock),
    .wr_en   (beat_p0),
    .wr_addr (wa_p0),
    .wr_data (lb1_q),
    .rd_en   (acc),
    .rd_addr (cur_x),
    .rd_data (lb0_q)
  );

  always_ff @(posedge clock) begin
    // p0: newest column is {lb0_q, lb1_q, pix_p0}
    if (acc) begin
      pix_p0  <= in_pix;
      wa_p0   <= cur_x;
      mode_p0 <= mode_cur;
    end
    // p1: window shift and signed gradients
    if (beat_p0) begin
      w0[0] <= w0[1];
      w0[1] <= lb0_q;
      w1[0] <= w1[1];
      w1[1] <= lb1_q;
      w2[0] <= w2[1];
      w2[1] <= pix_p0;
    end
    h_p1    <= -ext(w0[0]) + ext(lb0_q) - (ext(w1[0]) <<< 1) + (ext(lb1_q) <<< 1)
               - ext(w2[0]) + ext(pix_p0);
    v_p1    <= -ext(w0[0]) - (ext(w0[1]) <<< 1) - ext(lb0_q)
               + ext(w2[0]) + (ext(w2[1]) <<< 1) + ext(pix_p0);
    mode_p1 <= mode_p0;
    // p2: magnitudes
    ah_p2   <= mag(h_p1);
    av_p2   <= mag(v_p1);
    mode_p2 <= mode_p1;
  end

`ifdef SOBEL_THRESH_EN
  always_ff @(posedge clock) begin
    if (acc) thr_p0 <= thr_cur;
    thr_p1 <= thr_p0;
    thr_p2 <= thr_p1;
  end
`endif

  // p3: mode select and saturation into the output register
  always_comb begin
    sum_p2 = GW'(ah_p2) + GW'(av_p2);
    case (mode_p2)
      SOB_H:   s_p2 = GW'(ah_p2);
      SOB_V:   s_p2 = GW'(av_p2);
      default: s_p2 = sum_p2;
    endcase
    pix_res = PIX_W'(saturate(32'(s_p2), PMAX));
`ifdef SOBEL_THRESH_EN
    if (mode_p2 == SOB_THR) pix_res = (sum_p2 >= thr_p2) ? '1 : '0;
`endif
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed self-checking bench for sobel_stream (flat, edge, ramp, stall, threshold, reset).
module tb_sobel_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  line_len = '0;
  logic [1:0]  mode = '0;
  logic [11:0] thresh = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pix = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic [7:0]  out_pix;
  logic        out_sof;
  logic        out_eol;
  logic        err;

  sobel_stream dut (
    .clock     (clock),
    .reset     (reset),
    .line_len  (line_len),
    .mode      (mode),
    .thresh    (thresh),
    .in_valid  (in_valid),
    .in_pix    (in_pix),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_pix   (out_pix),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .err       (err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int q_pix[$];
  int q_cyc[$];
  bit q_sof[$];
  bit q_eol[$];
  int exp_cyc[$];

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      q_pix.push_back(int'(out_pix));
      q_cyc.push_back(cyc);
      q_sof.push_back(out_sof);
      q_eol.push_back(out_eol);
    end
  end

  task automatic clear_q();
    q_pix.delete();
    q_cyc.delete();
    q_sof.delete();
    q_eol.delete();
    exp_cyc.delete();
  endtask

  // kind: 0 flat 100, 1 vertical edge (0,0,255,...), 2 ramp 10*x
  task automatic run_frame(input int len, input int rows, input int kind,
                           input logic [1:0] md, input logic [11:0] th, input bit stall);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < len; x++) begin
        if (stall) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_pix   = 8'($urandom);
            @(negedge clock);
          end
        end
        line_len = 10'(len);
        mode     = md;
        thresh   = th;
        in_sof   = (x == 0) && (y == 0);
        in_pix   = (kind == 0) ? 8'd100 : (kind == 1) ? ((x >= 2) ? 8'd255 : 8'd0) : 8'(10 * x);
        in_valid = 1'b1;
        @(negedge clock);
        if (x >= 2 && y >= 2) exp_cyc.push_back(cyc);
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_chk++; if (out_pix !== 8'd0) begin n_err++; $display("FAIL rst_pix got %0d want 0", out_pix); end
    n_chk++; if (out_sof !== 1'b0) begin n_err++; $display("FAIL rst_sof got %b want 0", out_sof); end
    n_chk++; if (out_eol !== 1'b0) begin n_err++; $display("FAIL rst_eol got %b want 0", out_eol); end
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
    reset = 1'b0;
    @(negedge clock);
    clear_q();
    for (int i = 0; i < 30; i++) begin
      line_len = 10'd5; in_pix = 8'(i * 37); in_valid = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clock);
    n_chk++; if (q_pix.size() != 0) begin n_err++; $display("FAIL pre_sof_ignored got %0d outputs want 0", q_pix.size()); end
  endtask

  task automatic test_flat();
    clear_q();
    run_frame(5, 4, 0, 2'd0, 12'd0, 1'b0);
    n_chk++; if (q_pix.size() != 6) begin n_err++; $display("FAIL flat_count got %0d want 6", q_pix.size()); end
    for (int i = 0; i < 6 && i < q_pix.size(); i++) begin
      n_chk++; if (q_pix[i] != 0) begin n_err++; $display("FAIL flat_pix[%0d] got %0d want 0", i, q_pix[i]); end
      n_chk++; if (q_sof[i] != (i == 0)) begin n_err++; $display("FAIL flat_sof[%0d] got %b want %b", i, q_sof[i], i == 0); end
      n_chk++; if (q_eol[i] != (i % 3 == 2)) begin n_err++; $display("FAIL flat_eol[%0d] got %b want %b", i, q_eol[i], i % 3 == 2); end
    end
  endtask

  task automatic test_edge();
    logic [1:0] mlist [3];
    int want;
    mlist[0] = 2'd0; mlist[1] = 2'd2; mlist[2] = 2'd1;
    for (int m = 0; m < 3; m++) begin
      clear_q();
      run_frame(5, 4, 1, mlist[m], 12'd0, 1'b0);
      n_chk++; if (q_pix.size() != 6) begin n_err++; $display("FAIL edge_m%0d_count got %0d want 6", mlist[m], q_pix.size()); end
      for (int i = 0; i < 6 && i < q_pix.size(); i++) begin
        want = (mlist[m] == 2'd2 || i % 3 == 2) ? 0 : 255;
        n_chk++;
        if (q_pix[i] != want) begin n_err++; $display("FAIL edge_m%0d_pix[%0d] got %0d want %0d", mlist[m], i, q_pix[i], want); end
      end
      n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL edge_m%0d_err got %b want 0", mlist[m], err); end
    end
  endtask

  task automatic test_ramp(input bit stall);
    clear_q();
    run_frame(8, 4, 2, 2'd0, 12'd0, stall);
    n_chk++; if (q_pix.size() != 12) begin n_err++; $display("FAIL ramp%0d_count got %0d want 12", stall, q_pix.size()); end
    for (int i = 0; i < 12 && i < q_pix.size() && i < exp_cyc.size(); i++) begin
      n_chk++; if (q_pix[i] != 80) begin n_err++; $display("FAIL ramp%0d_pix[%0d] got %0d want 80", stall, i, q_pix[i]); end
      n_chk++; if (q_cyc[i] - exp_cyc[i] != 3) begin n_err++; $display("FAIL ramp%0d_lat[%0d] got %0d want 3", stall, i, q_cyc[i] - exp_cyc[i]); end
      n_chk++; if (q_eol[i] != (i % 6 == 5)) begin n_err++; $display("FAIL ramp%0d_eol[%0d] got %b want %b", stall, i, q_eol[i], i % 6 == 5); end
    end
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL ramp%0d_err got %b want 0", stall, err); end
  endtask

  task automatic test_thresh();
    int want;
`ifdef SOBEL_THRESH_EN
    logic [11:0] tl [2];
    tl[0] = 12'd500; tl[1] = 12'd1021;
    for (int t = 0; t < 2; t++) begin
      clear_q();
      run_frame(5, 4, 1, 2'd3, tl[t], 1'b0);
      n_chk++; if (q_pix.size() != 6) begin n_err++; $display("FAIL thr%0d_count got %0d want 6", tl[t], q_pix.size()); end
      for (int i = 0; i < 6 && i < q_pix.size(); i++) begin
        want = (t == 1 || i % 3 == 2) ? 0 : 255;
        n_chk++;
        if (q_pix[i] != want) begin n_err++; $display("FAIL thr%0d_pix[%0d] got %0d want %0d", tl[t], i, q_pix[i], want); end
      end
      n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL thr%0d_err got %b want 0", tl[t], err); end
    end
`else
    clear_q();
    run_frame(5, 4, 1, 2'd3, 12'd500, 1'b0);
    n_chk++; if (err !== 1'b1) begin n_err++; $display("FAIL mode3_err got %b want 1", err); end
    n_chk++; if (q_pix.size() != 6) begin n_err++; $display("FAIL mode3_count got %0d want 6", q_pix.size()); end
    for (int i = 0; i < 6 && i < q_pix.size(); i++) begin
      want = (i % 3 == 2) ? 0 : 255;
      n_chk++;
      if (q_pix[i] != want) begin n_err++; $display("FAIL mode3_pix[%0d] got %0d want %0d", i, q_pix[i], want); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int want;
    clear_q();
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 5 && !(y == 2 && x > 3); x++) begin
        line_len = 10'd5; mode = 2'd0;
        in_sof   = (x == 0) && (y == 0);
        in_pix   = (x >= 2) ? 8'd255 : 8'd0;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
    end
    repeat (2) @(negedge clock);
    n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
    #1 reset = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
    n_chk++; if (out_pix !== 8'd0) begin n_err++; $display("FAIL mid_async_pix got %0d want 0", out_pix); end
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    n_chk++; if (q_pix.size() != 1) begin n_err++; $display("FAIL mid_flush got %0d outputs want 1", q_pix.size()); end
    line_len = 10'd2; in_sof = 1'b1; in_valid = 1'b1; in_pix = 8'd0;
    @(negedge clock);
    in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clock);
    n_chk++; if (err !== 1'b1) begin n_err++; $display("FAIL badlen_err got %b want 1", err); end
    clear_q();
    run_frame(5, 4, 1, 2'd0, 12'd0, 1'b0);
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL recover_err got %b want 0", err); end
    n_chk++; if (q_pix.size() != 6) begin n_err++; $display("FAIL recover_count got %0d want 6", q_pix.size()); end
    for (int i = 0; i < 6 && i < q_pix.size(); i++) begin
      want = (i % 3 == 2) ? 0 : 255;
      n_chk++;
      if (q_pix[i] != want) begin n_err++; $display("FAIL recover_pix[%0d] got %0d want %0d", i, q_pix[i], want); end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_edge();
    test_ramp(1'b0);
    test_thresh();
    test_ramp(1'b1);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Parametrised streaming Sobel edge detector; next generation of the fixed 800x600 8-bit Sobel block.
- Accepts a raster pixel stream with valid and frame/line markers. Line length is set at run time up to MAX_X.
- Emits one gradient-magnitude pixel per full 3x3 window, with selectable output mode, saturation and border-aware framing.
- Sits between the video input stage and the frame writer in the image pipeline.

Parameters:
- PIX_W, 8, input/output pixel width in bits.
- MAX_X, 800, maximum line length in pixels; sets line-buffer depth.
- X_W, 10, width of column counter and line_len port; must satisfy 2^X_W >= MAX_X.

Ports:
- clock, in, 1, master clock; all logic rising-edge.
- reset, in, 1, asynchronous active-high reset.
- line_len, in, X_W, active pixels per line (3..MAX_X); sampled on accepted in_sof.
- mode, in, 2, 0=|H|+|V|, 1=|H|, 2=|V|, 3=threshold; sampled on accepted in_sof.
- thresh, in, PIX_W+4, threshold for mode 3; sampled on accepted in_sof.
- in_valid, in, 1, input pixel qualifier; no backpressure.
- in_pix, in, PIX_W, input pixel, unsigned.
- in_sof, in, 1, first pixel of frame; qualified by in_valid.
- out_valid, out, 1, output pixel qualifier.
- out_pix, out, PIX_W, gradient magnitude, unsigned.
- out_sof, out, 1, first output pixel of frame.
- out_eol, out, 1, last output pixel of line.
- err, out, 1, sticky error flag.

Behaviour:
- Reset: all outputs 0; counters 0; internal state idle. Line-buffer contents are don't-care.
- After reset, input is ignored until the first accepted in_sof.
- Input counters:
  - Accepted beat = in_valid=1.
  - in_sof beat sets x=0, y=0 and latches line_len, mode and thresh.
  - Otherwise x increments. When x = line_len_q-1, x wraps to 0 and y increments. y saturates at 2^16-1.
- Storage:
  - Two line buffers (depth MAX_X) are indexed by x, read-before-write.
  - lb1[x] receives the pixel from the previous line at x. lb0[x] receives the pixel from two lines back.
  - Three 3-register column shift chains form window w[r][c]; row 2 is the current line.
- Window validity: the window centred at (x-1, y-1) is valid iff the accepted pixel has x>=2 and y>=2. Output image is (line_len-2) x (rows-2).
- Arithmetic (signed, PIX_W+4 bits):
  - H = -w00 + w02 - 2w10 + 2w12 - w20 + w22.
  - V = -w00 - 2w01 - w02 + w20 + 2w21 + w22.
  - |H| and |V| are computed as unsigned values, PIX_W+3 bits.
  - Mode 0: S = |H|+|V|. Mode 1: S = |H|. Mode 2: S = |V|.
  - Modes 0-2: out_pix = min(S, 2^PIX_W-1), saturating (no bit truncation).
  - Mode 3: out_pix = all-ones if |H|+|V| >= thresh, else 0.
- Pipeline: stage 1 computes H/V, stage 2 computes abs, stage 3 does mode/saturate. out_valid is asserted exactly 3 cycles after the accepted pixel that completes a valid window.
- Framing:
  - out_sof = 1 on the first valid output after each in_sof (centre (1,1)).
  - out_eol = 1 when centre x = line_len_q-2.
  - Flags are pipelined with out_pix.
- Idle cycles (in_valid=0) do not advance counters or windows. In-flight pipeline results still drain on schedule.
- Error handling:
  - in_sof mid-frame: restarts the frame (x=y=0). In-flight outputs drain; no out_valid for the new frame until x>=2, y>=2.
  - line_len < 3 or > MAX_X latched: sets err; the block behaves as if line_len = MAX_X.
  - err is cleared only by reset or the next in_sof with a legal line_len.
- Reset mid-frame: pipeline flushed; out_valid drops within the same cycle (asynchronous); block waits for in_sof.

Optional Feature:
- SOBEL_THRESH_EN defined: mode 3 is implemented as specified.
- SOBEL_THRESH_EN undefined:
  - Threshold comparator is omitted; thresh is ignored.
  - mode=3 is treated as mode 0 and sets err at sof.

Decomposition:
- sobel_pkg contains:
  - mode enum (SOB_SUM, SOB_H, SOB_V, SOB_THR);
  - localparam GRAD_W = PIX_W+4;
  - pipeline latency constant SOB_LAT = 3;
  - saturate function.
- Sub-module sobel_line_buf: parametrised MAX_X x PIX_W dual-port RAM; read-before-write, 1-cycle read. Instantiated twice.

Test Plan:
- Flat image 5x4, all pixels 100, mode 0 -> 6 outputs, all 0. out_sof on first output; out_eol on every 3rd output.
- Vertical edge, line_len=5, columns 0,0,255,255,255, 4 rows:
  - mode 0 -> 255,255,0 per line (H=1020 saturated);
  - mode 2 -> 0,0,0;
  - mode 1 -> 255,255,0.
- Ramp, pixel=10*x, line_len=8, mode 0 -> every output 80 (H=80, V=0). Latency is exactly 3 cycles after each completing input.
- SOBEL_THRESH_EN, vertical-edge image, mode 3, thresh=500 -> 255,255,0. With thresh=1021 -> 0,0,0.
- Stalls: random in_valid gaps on the ramp image -> identical out_pix sequence to the no-gap case. No out_valid without a completing input.
- Reset asserted at y=2, x=3 -> outputs 0 immediately. Then line_len=2 with sof -> err=1. Then a legal sof -> err=0 and correct output.
